// File: rtl/turing_machine_gen.sv
// Programmable Turing machine: load a transition table with Next pulses, then step the tape head.
// Optional macro TM_AUTORUN_EN adds an Auto input that steps the machine every clock in RUN.
module turing_machine_gen #(
  parameter int SYM_W      = 1,
  parameter int NUM_STATES = 4,
  parameter int TAPE_LEN   = 64,
  parameter int WIN        = 5,
  parameter int IN_W       = 4
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [IN_W-1:0]                 input_data,
`ifdef TM_AUTORUN_EN
  input  logic                            Auto,
`endif
  input  logic                            Next,
  input  logic                            Done,
  output logic [(2*WIN+1)*SYM_W-1:0]      display_out,
  output logic                            Compute_done,
  output logic                            fault,
  output logic                            loading,
  output logic [$clog2(NUM_STATES)-1:0]   cur_state,
  output logic [15:0]                     step_count,
  output logic [1:0]                      fsm_state
);

  localparam int ST_W    = $clog2(NUM_STATES);
  localparam int HW      = $clog2(TAPE_LEN);
  localparam int IDX_W   = ST_W + SYM_W;
  localparam int NSLOT   = 2 ** IDX_W;
  localparam int NUM_ENT = (NUM_STATES - 1) * (2 ** SYM_W);
  localparam logic [ST_W-1:0] HALT_S = ST_W'(NUM_STATES - 1);

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_RUN = 2'd1, S_HALTED = 2'd2} mode_t;

  mode_t              mode;
  logic               next_q;
  logic [IDX_W:0]     ent_idx;
  logic [1:0]         fld;
  logic [SYM_W-1:0]   wsym  [NSLOT];
  logic               wkeep [NSLOT];
  logic [1:0]         mv    [NSLOT];
  logic [ST_W-1:0]    nst   [NSLOT];
  logic [SYM_W-1:0]   tape  [TAPE_LEN];
  logic [HW-1:0]      head;
  logic [ST_W-1:0]    state_q;
  logic [15:0]        steps;
  logic               done_q;
  logic               fault_q;

  // Handshake: a step/capture event is the first clock edge that samples Next=1
  // after an edge that sampled Next=0; holding Next high yields no further events.
  logic               next_ev;
  logic               step_ev;
  logic [SYM_W-1:0]   rd_sym;
  logic [IDX_W-1:0]   idx;
  logic [SYM_W-1:0]   wr_sym;
  logic [1:0]         mv_c;
  logic [ST_W-1:0]    ns_c;
  logic               off_tape;
  logic               unused_ok;

  assign unused_ok = &{1'b0, input_data};

  always_comb begin
    next_ev = Next & ~next_q;
`ifdef TM_AUTORUN_EN
    step_ev = next_ev | Auto;
`else
    step_ev = next_ev;
`endif
    rd_sym   = tape[head];
    idx      = {state_q, rd_sym};
    wr_sym   = wkeep[idx] ? rd_sym : wsym[idx];
    mv_c     = mv[idx];
    ns_c     = nst[idx];
    off_tape = ((mv_c == 2'd0) && (head == '0)) ||
               ((mv_c == 2'd1) && (head == HW'(TAPE_LEN - 1)));
  end

  // Cells outside the tape read as zero; MSB field is the leftmost cell.
  always_comb begin
    int c;
    display_out = '0;
    c = 0;
    for (int i = 0; i < 2*WIN+1; i++) begin
      c = int'(head) - WIN + i;
      if (c >= 0 && c < TAPE_LEN)
        display_out[(2*WIN-i)*SYM_W +: SYM_W] = tape[c[HW-1:0]];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode    <= S_LOAD;
      next_q  <= 1'b0;
      ent_idx <= '0;
      fld     <= 2'd0;
      head    <= HW'(TAPE_LEN / 2);
      state_q <= '0;
      steps   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        wsym[i]  <= '0;
        wkeep[i] <= 1'b1;
        mv[i]    <= 2'd2;
        nst[i]   <= HALT_S;
      end
      for (int i = 0; i < TAPE_LEN; i++) tape[i] <= '0;
    end else begin
      next_q <= Next;
      case (mode)
        S_LOAD: begin
          if (Done) begin
            mode    <= S_RUN;
            state_q <= '0;
            head    <= HW'(TAPE_LEN / 2);
            steps   <= '0;
            for (int i = 0; i < TAPE_LEN; i++) tape[i] <= '0;
          end else if (next_ev && (ent_idx < (IDX_W+1)'(NUM_ENT))) begin
            case (fld)
              2'd0: begin
                wsym[ent_idx[IDX_W-1:0]]  <= input_data[SYM_W-1:0];
                wkeep[ent_idx[IDX_W-1:0]] <= 1'b0;
                fld <= 2'd1;
              end
              2'd1: begin
                mv[ent_idx[IDX_W-1:0]] <= input_data[1:0];
                fld <= 2'd2;
              end
              default: begin
                nst[ent_idx[IDX_W-1:0]] <= input_data[ST_W-1:0];
                fld     <= 2'd0;
                ent_idx <= ent_idx + 1'b1;
              end
            endcase
          end
        end
        S_RUN: begin
          if (step_ev) begin
            tape[head] <= wr_sym;
            state_q    <= ns_c;
            if (steps != 16'hFFFF) steps <= steps + 16'd1;
            // Falling off either end commits the write but freezes the head.
            if (off_tape) begin
              fault_q <= 1'b1;
              done_q  <= 1'b1;
              mode    <= S_HALTED;
            end else begin
              if (mv_c == 2'd0)      head <= head - 1'b1;
              else if (mv_c == 2'd1) head <= head + 1'b1;
              if (ns_c == HALT_S) begin
                done_q <= 1'b1;
                mode   <= S_HALTED;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign Compute_done = done_q;
  assign fault        = fault_q;
  assign loading      = (mode == S_LOAD);
  assign cur_state    = state_q;
  assign step_count   = steps;
  assign fsm_state    = mode;

endmodule

// File: tb/tb_turing_machine_gen.sv
// Directed bench for turing_machine_gen: default 64-cell instance plus an 8-cell instance for edge faults.
module tb_turing_machine_gen;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  din = '0, din8 = '0;
  logic        nxt = 1'b0, nxt8 = 1'b0;
  logic        dn = 1'b0, dn8 = 1'b0;
  logic        auto_a = 1'b0, auto8 = 1'b0;
  logic [10:0] disp, disp8;
  logic        cdone, cdone8, flt, flt8, ld, ld8;
  logic [1:0]  cst, cst8, fsm, fsm8;
  logic [15:0] sc, sc8;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  turing_machine_gen dut (
    .clock(clock), .reset_n(reset_n), .input_data(din),
`ifdef TM_AUTORUN_EN
    .Auto(auto_a),
`endif
    .Next(nxt), .Done(dn), .display_out(disp), .Compute_done(cdone),
    .fault(flt), .loading(ld), .cur_state(cst), .step_count(sc), .fsm_state(fsm)
  );

  turing_machine_gen #(.TAPE_LEN(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .input_data(din8),
`ifdef TM_AUTORUN_EN
    .Auto(auto8),
`endif
    .Next(nxt8), .Done(dn8), .display_out(disp8), .Compute_done(cdone8),
    .fault(flt8), .loading(ld8), .cur_state(cst8), .step_count(sc8), .fsm_state(fsm8)
  );

  // ---------------- driver tasks (start and end on a falling edge) ----------------
  task automatic pulse(input bit t8, input logic [3:0] d);
    if (t8) begin nxt8 = 1'b1; din8 = d; end
    else    begin nxt  = 1'b1; din  = d; end
    @(negedge clock);
    nxt = 1'b0; nxt8 = 1'b0;
    @(negedge clock);
  endtask

  task automatic finish_load(input bit t8);
    if (t8) dn8 = 1'b1; else dn = 1'b1;
    @(negedge clock);
    dn = 1'b0; dn8 = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic load_prog_a();
    logic [3:0] f [9];
    f = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};
    for (int i = 0; i < 9; i++) pulse(1'b0, f[i]);
    finish_load(1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (disp !== 11'b0) begin errors++; $display("FAIL reset_disp: got %b exp %b", disp, 11'b0); end
    checks++; if (ld !== 1'b1) begin errors++; $display("FAIL reset_loading: got %b exp 1", ld); end
    checks++; if (cdone !== 1'b0 || flt !== 1'b0) begin errors++; $display("FAIL reset_done_fault: got %b%b exp 00", cdone, flt); end
    checks++; if (cst !== 2'd0 || sc !== 16'd0 || fsm !== 2'd0) begin errors++; $display("FAIL reset_state: got cs=%0d sc=%0d fsm=%0d exp 0 0 0", cst, sc, fsm); end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_program_a();
    load_prog_a();
    checks++; if (ld !== 1'b0 || sc !== 16'd0 || cst !== 2'd0) begin errors++; $display("FAIL run_entry: got ld=%b sc=%0d cs=%0d exp 0 0 0", ld, sc, cst); end
    pulse(1'b0, 4'd0);
    checks++; if (disp !== 11'b00001_0_00000) begin errors++; $display("FAIL prog_a_step1_disp: got %b exp %b", disp, 11'b00001_0_00000); end
    checks++; if (cst !== 2'd1 || sc !== 16'd1 || cdone !== 1'b0) begin errors++; $display("FAIL prog_a_step1_state: got cs=%0d sc=%0d done=%b exp 1 1 0", cst, sc, cdone); end
    pulse(1'b0, 4'd0);
    checks++; if (disp !== 11'b00001_1_00000) begin errors++; $display("FAIL prog_a_step2_disp: got %b exp %b", disp, 11'b00001_1_00000); end
    checks++; if (cst !== 2'd3 || sc !== 16'd2 || cdone !== 1'b1 || flt !== 1'b0) begin errors++; $display("FAIL prog_a_step2_state: got cs=%0d sc=%0d done=%b flt=%b exp 3 2 1 0", cst, sc, cdone, flt); end
  endtask

  task automatic test_halted_ignores();
    pulse(1'b0, 4'd0);
    finish_load(1'b0);
    checks++; if (sc !== 16'd2 || disp !== 11'b00001_1_00000 || ld !== 1'b0 || fsm !== 2'd2) begin errors++; $display("FAIL halted_ignore: got sc=%0d disp=%b ld=%b fsm=%0d exp 2 00001100000 0 2", sc, disp, ld, fsm); end
  endtask

  task automatic test_held_next();
    do_reset();
    load_prog_a();
    finish_load(1'b0);
    checks++; if (ld !== 1'b0 || sc !== 16'd0) begin errors++; $display("FAIL done_in_run: got ld=%b sc=%0d exp 0 0", ld, sc); end
    nxt = 1'b1;
    repeat (5) @(negedge clock);
    nxt = 1'b0;
    @(negedge clock);
    checks++; if (sc !== 16'd1 || cst !== 2'd1 || disp !== 11'b00001_0_00000) begin errors++; $display("FAIL held_next: got sc=%0d cs=%0d disp=%b exp 1 1 00001000000", sc, cst, disp); end
  endtask

  task automatic test_reset_mid_run();
    reset_n = 1'b0;
    #1;
    checks++; if (disp !== 11'b0 || ld !== 1'b1 || cdone !== 1'b0 || flt !== 1'b0 || cst !== 2'd0 || sc !== 16'd0) begin
      errors++; $display("FAIL mid_run_reset: got disp=%b ld=%b done=%b flt=%b cs=%0d sc=%0d exp all reset", disp, ld, cdone, flt, cst, sc); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    test_program_a();
  endtask

  task automatic test_done_wins();
    do_reset();
    nxt = 1'b1; din = 4'd1; dn = 1'b1;
    @(negedge clock);
    nxt = 1'b0; dn = 1'b0;
    @(negedge clock);
    checks++; if (ld !== 1'b0) begin errors++; $display("FAIL done_wins_mode: got ld=%b exp 0", ld); end
    pulse(1'b0, 4'd0);
    checks++; if (disp !== 11'b0 || cst !== 2'd3 || cdone !== 1'b1 || sc !== 16'd1) begin
      errors++; $display("FAIL default_entry: got disp=%b cs=%0d done=%b sc=%0d exp 0 3 1 1", disp, cst, cdone, sc); end
  endtask

  task automatic test_fault_right();
    do_reset();
    pulse(1'b1, 4'd0); pulse(1'b1, 4'd1); pulse(1'b1, 4'd0);
    finish_load(1'b1);
    repeat (3) pulse(1'b1, 4'd0);
    checks++; if (flt8 !== 1'b0 || cdone8 !== 1'b0 || sc8 !== 16'd3) begin errors++; $display("FAIL pre_fault: got flt=%b done=%b sc=%0d exp 0 0 3", flt8, cdone8, sc8); end
    pulse(1'b1, 4'd0);
    checks++; if (flt8 !== 1'b1 || cdone8 !== 1'b1 || sc8 !== 16'd4) begin errors++; $display("FAIL fault_right: got flt=%b done=%b sc=%0d exp 1 1 4", flt8, cdone8, sc8); end
    checks++; if (dut8.head !== 3'd7) begin errors++; $display("FAIL fault_head: got %0d exp 7", dut8.head); end
    pulse(1'b1, 4'd0);
    checks++; if (sc8 !== 16'd4) begin errors++; $display("FAIL fault_halted: got sc=%0d exp 4", sc8); end
  endtask

  task automatic test_fault_marks();
    do_reset();
    pulse(1'b1, 4'd1); pulse(1'b1, 4'd1); pulse(1'b1, 4'd0);
    finish_load(1'b1);
    pulse(1'b1, 4'd0);
    checks++; if (disp8 !== 11'b00001_0_00000) begin errors++; $display("FAIL marks_step1: got %b exp %b", disp8, 11'b00001_0_00000); end
    repeat (3) pulse(1'b1, 4'd0);
    checks++; if (disp8 !== 11'b00111_1_00000 || flt8 !== 1'b1) begin errors++; $display("FAIL marks_right_edge: got disp=%b flt=%b exp 00111100000 1", disp8, flt8); end
  endtask

  task automatic test_fault_left();
    do_reset();
    pulse(1'b1, 4'd1); pulse(1'b1, 4'd0); pulse(1'b1, 4'd0);
    finish_load(1'b1);
    repeat (4) pulse(1'b1, 4'd0);
    checks++; if (flt8 !== 1'b0 || sc8 !== 16'd4) begin errors++; $display("FAIL left_pre: got flt=%b sc=%0d exp 0 4", flt8, sc8); end
    pulse(1'b1, 4'd0);
    checks++; if (disp8 !== 11'b00000_1_11110 || flt8 !== 1'b1 || cdone8 !== 1'b1 || sc8 !== 16'd5) begin
      errors++; $display("FAIL left_edge: got disp=%b flt=%b done=%b sc=%0d exp 00000111110 1 1 5", disp8, flt8, cdone8, sc8); end
  endtask

`ifdef TM_AUTORUN_EN
  task automatic test_autorun();
    do_reset();
    load_prog_a();
    auto_a = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++; if (cdone !== 1'b1 || sc !== 16'd2 || disp !== 11'b00001_1_00000) begin
      errors++; $display("FAIL autorun: got done=%b sc=%0d disp=%b exp 1 2 00001100000", cdone, sc, disp); end
    auto_a = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_program_a();
    test_halted_ignores();
    test_held_next();
    test_reset_mid_run();
    test_done_wins();
    test_fault_right();
    test_fault_marks();
    test_fault_left();
`ifdef TM_AUTORUN_EN
    test_autorun();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/turing_machine_gen.md
TURING_MACHINE_GEN -- requirements
Module: turing_machine_gen

Interface
REQ-001 SHALL have parameter SYM_W, default 1: tape symbol width in bits; legal range 1..IN_W.
REQ-002 SHALL have parameter NUM_STATES, default 4: number of states including the halt state; NUM_STATES-1 is HALT.
REQ-003 SHALL have parameter TAPE_LEN, default 64: tape cell count, a power of 2 and at least 4.
REQ-004 SHALL have parameters WIN, default 5 (display half-window in cells), and IN_W, default 4 (program input width).
REQ-005 SHALL have port clock, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port input_data, input, IN_W bits: program field value, captured on a Next rising edge.
REQ-008 SHALL have ports Next and Done, inputs, 1 bit each, synchronous to clock: Next captures a field or steps the machine; Done ends loading.
REQ-009 SHALL have port display_out, output, (2*WIN+1)*SYM_W bits: tape window around the head.
REQ-010 SHALL have ports Compute_done, fault and loading, outputs, 1 bit each: halted, head left the tape, in load mode.
REQ-011 SHALL have ports cur_state, output, clog2(NUM_STATES) bits, and step_count, output, 16 bits.

Function
REQ-012 SHALL run an FSM with states LOAD, RUN and HALTED; loading=1 only in LOAD.
REQ-013 SHALL detect a Next rising edge as Next=1 while the Next value registered on the previous edge was 0; a held Next produces exactly one event.
REQ-014 LOAD: each Next event SHALL capture input_data[SYM_W-1:0] or input_data[clog2(NUM_STATES)-1:0] into the next program field.
REQ-015 Program field order SHALL be entry e = s*2^SYM_W + v for s in 0..NUM_STATES-2 and every symbol v; each entry is {write_sym, move, next_state}.
REQ-016 move encoding SHALL be 0=left, 1=right, 2 or 3=stay.
REQ-017 Entries not loaded before Done SHALL default to {write the symbol read, stay, HALT}.
REQ-018 Next events after the last field SHALL be ignored; Next and Done on the same edge SHALL mean Done wins and the capture is discarded.
REQ-019 Done=1 in LOAD SHALL enter RUN with cur_state=0, head=TAPE_LEN/2, tape all zero and step_count=0.
REQ-020 RUN: each Next event SHALL perform one step in that edge: read tape[head], write write_sym, move head, load next_state, increment step_count.
REQ-021 display_out and all outputs SHALL reflect the step after that same edge (one-edge latency from the sampled Next).
REQ-022 display_out SHALL place cell head-WIN in its MSB field, head in the middle field and head+WIN in its LSB field; cells outside 0..TAPE_LEN-1 SHALL show 0.
REQ-023 next_state==HALT SHALL enter HALTED and set Compute_done=1 on the step's edge; HALTED SHALL ignore Next and Done until reset.
REQ-024 A move left from head 0 or right from head TAPE_LEN-1 SHALL commit the write, keep the head in place, set fault=1 and Compute_done=1, and enter HALTED.
REQ-025 step_count SHALL saturate at 16'hFFFF.
REQ-026 Done in RUN SHALL be ignored.

Reset
REQ-027 reset_n=0 SHALL immediately force LOAD: display_out=0, Compute_done=0, fault=0, loading=1, cur_state=0, step_count=0, field pointer 0, all entries at their default, tape zeroed.
REQ-028 Reset asserted mid-load or mid-run SHALL discard all program and tape contents.

Configuration
REQ-029 With macro TM_AUTORUN_EN defined, the block SHALL add input Auto (1 bit); in RUN, Auto=1 SHALL perform one step every clock without Next, and a simultaneous Next event SHALL still give exactly one step per clock.
REQ-030 Without TM_AUTORUN_EN, the Auto port and its logic SHALL be absent, and only Next events SHALL step the machine.

Verification
REQ-031 Reset with default parameters -> display_out=0, loading=1, Compute_done=0, fault=0.
REQ-032 Load (0,0)={1,1,1}, (0,1)={0,2,3}, (1,0)={1,2,3}, then Done, then Next -> display_out=11'b00001_0_00000, cur_state=1; second Next -> 11'b00001_1_00000, Compute_done=1, cur_state=3, step_count=2.
REQ-033 Next held high 5 cycles in RUN -> exactly one step; step_count increments by 1.
REQ-034 TAPE_LEN=8, (0,0)={0,1,0}, then 4 Next events -> fault=1 and Compute_done=1 after the 4th event, head stays at 7, step_count=4.
REQ-035 reset_n low for 1 cycle mid-RUN -> all outputs at reset values, loading=1; reloading the same program reproduces REQ-032.
REQ-036 With TM_AUTORUN_EN, program from REQ-032 and Auto=1 -> Compute_done=1 two clocks after entering RUN, with no Next pulses.
